// File: rtl/tile_config_frame_mem.sv
// Double-buffered, flop-based configuration memory for an eFPGA tile.
// Frames land in a shadow buffer. A commit copies them one per cycle into the
// active buffer, and the active buffer drives ConfigBits / ConfigBits_N.
// Readback of either buffer and sticky address-error reporting are included.
module tile_config_frame_mem #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NoConfigBits    = 640,
  parameter int FrameAddrWidth  = 5
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [FrameAddrWidth-1:0]  wr_frame,
  input  logic [FrameBitsPerRow-1:0] wr_data,
  input  logic                       commit,
  output logic                       commit_done,
  output logic                       busy,
  output logic                       dirty,
  input  logic                       rd_req,
  input  logic                       rd_shadow,
  input  logic [FrameAddrWidth-1:0]  rd_frame,
  output logic [FrameBitsPerRow-1:0] rd_data,
  output logic                       rd_data_valid,
  output logic                       err,
  output logic [NoConfigBits-1:0]    ConfigBits,
  output logic [NoConfigBits-1:0]    ConfigBits_N
);

  localparam int CNT_W      = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
  localparam int TOTAL_BITS = MaxFramesPerCol * FrameBitsPerRow;

  typedef enum logic {IDLE, COMMIT} state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [FrameBitsPerRow-1:0] shadow_q [MaxFramesPerCol];
  logic [FrameBitsPerRow-1:0] active_q [MaxFramesPerCol];
  logic                       dirty_q, err_q, rd_valid_q;
  logic [FrameBitsPerRow-1:0] rd_data_q;
  logic [TOTAL_BITS-1:0]      active_flat;

  logic             wr_fire, wr_in_range, rd_in_range, last_frame;
  logic [CNT_W-1:0] wr_idx, rd_idx;

  // Address decode. The frame address may be wider than the counter, so the
  // range check uses the full address and only the low bits index storage.
  assign wr_in_range = 32'(wr_frame) < 32'(MaxFramesPerCol);
  assign rd_in_range = 32'(rd_frame) < 32'(MaxFramesPerCol);
  assign wr_idx      = wr_frame[CNT_W-1:0];
  assign rd_idx      = rd_frame[CNT_W-1:0];
  assign last_frame  = 32'(cnt_q) == 32'(MaxFramesPerCol - 1);

  // The shadow is frozen while committing, so writes are refused until the copy is done.
  assign wr_ready    = (state_q == IDLE) && !reset;
  assign wr_fire     = wr_valid && wr_ready;
  assign busy        = (state_q == COMMIT);
  assign commit_done = (state_q == COMMIT) && last_frame;

  assign dirty         = dirty_q;
  assign err           = err_q;
  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_valid_q;

  // Next-state logic: a commit walks the frame counter from 0 to the last frame.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (commit) begin
          state_d = COMMIT;
          cnt_d   = '0;
        end
      end
      COMMIT: begin
        if (last_frame) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and frame-counter registers. Reset abandons any commit in progress.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The shadow buffer takes in-range accepted writes.
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int f = 0; f < MaxFramesPerCol; f++) shadow_q[f] <= '0;
    end else if (wr_fire && wr_in_range) begin
      shadow_q[wr_idx] <= wr_data;
    end
  end

  // The active buffer copies one shadow frame per commit cycle.
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int f = 0; f < MaxFramesPerCol; f++) active_q[f] <= '0;
    end else if (state_q == COMMIT) begin
      active_q[cnt_q] <= shadow_q[cnt_q];
    end
  end

  // Track the dirty flag and the sticky error flag.
  // A write accepted in the same cycle as a commit start is part of that commit, so clear wins.
  always_ff @(posedge CLK) begin
    if (reset) begin
      dirty_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && commit) begin
        dirty_q <= 1'b0;
      end else if (wr_fire && wr_in_range) begin
        dirty_q <= 1'b1;
      end
      if ((wr_fire && !wr_in_range) || (rd_req && !rd_in_range)) begin
        err_q <= 1'b1;
      end
    end
  end

  // Registered readback. It captures the buffer contents as they stand at the request edge.
  always_ff @(posedge CLK) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_req;
      if (rd_req) begin
        if (!rd_in_range) begin
          rd_data_q <= '0;
        end else if (rd_shadow) begin
          rd_data_q <= shadow_q[rd_idx];
        end else begin
          rd_data_q <= active_q[rd_idx];
        end
      end
    end
  end

  // Flatten the active frames so that frame f occupies bits [f*FrameBitsPerRow +: FrameBitsPerRow].
  for (genvar gi = 0; gi < MaxFramesPerCol; gi++) begin : g_flat
    assign active_flat[gi*FrameBitsPerRow +: FrameBitsPerRow] = active_q[gi];
  end

  if (NoConfigBits > 0) begin : g_cfg
    assign ConfigBits   = active_flat[NoConfigBits-1:0];
    assign ConfigBits_N = ~active_flat[NoConfigBits-1:0];
  end else begin : g_no_cfg
    assign ConfigBits   = '0;
    assign ConfigBits_N = '1;
  end

endmodule

// File: tb/tb_tile_config_frame_mem.sv
// Randomized and directed bench for tile_config_frame_mem with a frame-level reference model.
module tb_tile_config_frame_mem;

  localparam int NF  = 20;
  localparam int FB  = 32;
  localparam int NCB = 640;
  localparam int AW  = 5;

  logic           CLK = 1'b0;
  logic           reset;
  logic           wr_valid, wr_ready, commit, commit_done, busy, dirty;
  logic [AW-1:0]  wr_frame, rd_frame;
  logic [FB-1:0]  wr_data, rd_data;
  logic           rd_req, rd_shadow, rd_data_valid, err;
  logic [NCB-1:0] ConfigBits, ConfigBits_N;

  always #5 CLK = ~CLK;

  tile_config_frame_mem #(
    .MaxFramesPerCol(NF), .FrameBitsPerRow(FB), .NoConfigBits(NCB), .FrameAddrWidth(AW)
  ) dut (
    .CLK(CLK), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_frame(wr_frame), .wr_data(wr_data),
    .commit(commit), .commit_done(commit_done), .busy(busy), .dirty(dirty),
    .rd_req(rd_req), .rd_shadow(rd_shadow), .rd_frame(rd_frame),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .err(err),
    .ConfigBits(ConfigBits), .ConfigBits_N(ConfigBits_N)
  );

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int done_pulses = 0;

  // Reference model: the two frame buffers plus the progress of a commit.
  logic [FB-1:0] m_sh [NF];
  logic [FB-1:0] m_ac [NF];
  bit            m_committing;
  int            m_next;       // next frame to copy while committing
  bit            m_dirty, m_err, m_rdv;
  logic [FB-1:0] m_rdd;

  task automatic chk(input string tag, input logic [NCB-1:0] got, input logic [NCB-1:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NCB-1:0] model_cfg();
    logic [NCB-1:0] r;
    for (int i = 0; i < NCB; i++) r[i] = m_ac[i / FB][i % FB];
    return r;
  endfunction

  // Apply one rising edge to the model using the inputs present at that edge.
  task automatic model_edge();
    logic [FB-1:0] rd_val;
    if (reset) begin
      for (int f = 0; f < NF; f++) begin
        m_sh[f] = '0;
        m_ac[f] = '0;
      end
      m_committing = 0; m_next = 0; m_dirty = 0; m_err = 0; m_rdv = 0; m_rdd = '0;
      return;
    end
    // Readback sees the buffers as they were before this edge.
    m_rdv = rd_req;
    if (rd_req) begin
      if (int'(rd_frame) >= NF) begin
        rd_val = '0;
        m_err  = 1;
      end else begin
        rd_val = rd_shadow ? m_sh[rd_frame] : m_ac[rd_frame];
      end
      m_rdd = rd_val;
    end
    if (m_committing) begin
      m_ac[m_next] = m_sh[m_next];
      m_next++;
      if (m_next == NF) m_committing = 0;
    end else begin
      if (wr_valid) begin
        if (int'(wr_frame) < NF) begin
          m_sh[wr_frame] = wr_data;
          m_dirty = 1;
        end else begin
          m_err = 1;
        end
      end
      if (commit) begin
        m_committing = 1;
        m_next  = 0;
        m_dirty = 0;
      end
    end
  endtask

  task automatic check_outputs();
    chk("cfg", ConfigBits, model_cfg());
    chk("cfg_n", ConfigBits_N, ~model_cfg());
    chk("busy", NCB'(busy), NCB'(m_committing));
    chk("commit_done", NCB'(commit_done), NCB'(m_committing && m_next == NF - 1));
    chk("wr_ready", NCB'(wr_ready), NCB'(!m_committing && !reset));
    chk("dirty", NCB'(dirty), NCB'(m_dirty));
    chk("err", NCB'(err), NCB'(m_err));
    chk("rd_valid", NCB'(rd_data_valid), NCB'(m_rdv));
    chk("rd_data", NCB'(rd_data), NCB'(m_rdd));
  endtask

  task automatic cyc();
    @(posedge CLK);
    model_edge();
    #1;
    check_outputs();
    if (commit_done) done_pulses++;
  endtask

  task automatic idle_in();
    wr_valid = 0; wr_frame = '0; wr_data = '0; commit = 0;
    rd_req = 0; rd_shadow = 0; rd_frame = '0;
  endtask

  // Step until busy drops, counting busy cycles. A missing completion counts as a failure.
  task automatic run_commit(output int busy_cycles);
    busy_cycles = busy ? 1 : 0;
    for (int i = 0; i < 40 && busy; i++) begin
      cyc();
      if (busy) busy_cycles++;
    end
    if (busy) chk("commit_timeout", NCB'(busy), '0);
  endtask

  int bc;

  initial begin
    idle_in();
    reset = 1;
    cyc(); cyc();
    reset = 0;
    cyc();
    chk("rst_cfg", ConfigBits, '0);
    chk("rst_cfg_n", ConfigBits_N, '1);
    chk("rst_ready", NCB'(wr_ready), NCB'(1));

    // Shadow write without commit leaves the active buffer untouched.
    wr_valid = 1; wr_frame = 3; wr_data = 32'hDEADBEEF;
    cyc();
    idle_in(); rd_req = 1; rd_shadow = 0; rd_frame = 3;
    cyc();
    chk("act3", NCB'(rd_data), '0);
    chk("dirty_set", NCB'(dirty), NCB'(1));
    rd_shadow = 1;
    cyc();
    chk("sh3", NCB'(rd_data), NCB'(32'hDEADBEEF));
    chk("sh3_valid", NCB'(rd_data_valid), NCB'(1));
    idle_in();
    cyc();

    // Commit frames 0 and 19 while a write is held stalled.
    wr_valid = 1; wr_frame = 0;  wr_data = 32'hFFFFFFFF; cyc();
    wr_frame = 19; cyc();
    idle_in(); commit = 1; cyc();
    commit = 0; wr_valid = 1; wr_frame = 5; wr_data = 32'hA5A5A5A5;
    done_pulses = 0;
    cyc();
    chk("first_frame", NCB'(ConfigBits[31:0]), NCB'(32'hFFFFFFFF));
    run_commit(bc);
    wr_valid = 0;
    chk("busy_len", NCB'(bc + 1), NCB'(NF));
    chk("done_once", NCB'(done_pulses), NCB'(1));
    chk("last_frame", NCB'(ConfigBits[639:608]), NCB'(32'hFFFFFFFF));
    chk("dirty_clr", NCB'(dirty), '0);
    cyc();

    // A write on the commit edge is included in that commit.
    wr_valid = 1; wr_frame = 0; wr_data = 32'h12345678; commit = 1;
    cyc();
    idle_in();
    run_commit(bc);
    rd_req = 1; rd_shadow = 0; rd_frame = 0;
    cyc();
    chk("samecyc_act0", NCB'(rd_data), NCB'(32'h12345678));
    chk("samecyc_dirty", NCB'(dirty), '0);
    idle_in();

    // Out-of-range write and read.
    wr_valid = 1; wr_frame = 25; wr_data = 32'hCAFEF00D; cyc();
    idle_in(); rd_req = 1; rd_shadow = 1; rd_frame = 31; cyc();
    chk("oor_rd", NCB'(rd_data), '0);
    chk("err_sticky", NCB'(err), NCB'(1));
    idle_in(); cyc();
    chk("err_holds", NCB'(err), NCB'(1));

    // Reset in the middle of a commit, followed by a clean commit of the zeroed shadow.
    commit = 1; cyc(); commit = 0;
    for (int i = 0; i < 6; i++) cyc();
    reset = 1; cyc(); reset = 0;
    chk("mid_rst_busy", NCB'(busy), '0);
    chk("mid_rst_cfg", ConfigBits, '0);
    commit = 1; cyc(); commit = 0;
    run_commit(bc);
    chk("post_rst_len", NCB'(bc), NCB'(NF));
    chk("post_rst_cfg", ConfigBits, '0);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      reset    = ($urandom_range(0, 199) == 0);
      wr_valid = $urandom_range(0, 1);
      wr_frame = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(NF, 31)) : AW'($urandom_range(0, NF - 1));
      wr_data  = $urandom;
      commit   = ($urandom_range(0, 15) == 0);
      rd_req   = $urandom_range(0, 1);
      rd_shadow = $urandom_range(0, 1);
      rd_frame = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(NF, 31)) : AW'($urandom_range(0, NF - 1));
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
